// File: rtl/sonar_ranger.sv
// Ultrasonic ranger: fires a trigger pulse, times the synchronized echo and converts the high time to mm.
// One result strobe per accepted start; start is ignored while busy.
module sonar_ranger #(
    parameter int FREQ         = 50_000_000,
    parameter int TRIG_US      = 10,
    parameter int ECHO_WAIT_US = 30000,
    parameter int MAX_ECHO_US  = 30000,
    parameter int HOLDOFF_US   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        valid,
    output logic        timeout,
    output logic [15:0] distance_mm
);

    localparam longint FREQ_L     = longint'(FREQ);
    localparam longint TRIG_CYC_L = longint'(TRIG_US) * FREQ_L / 1_000_000;
    localparam longint WAIT_CYC_L = longint'(ECHO_WAIT_US) * FREQ_L / 1_000_000;
    localparam longint MAX_CYC_L  = longint'(MAX_ECHO_US) * FREQ_L / 1_000_000;
    localparam longint HOLD_CYC_L = longint'(HOLDOFF_US) * FREQ_L / 1_000_000;
    localparam longint NM_L       = 343210 * (1_000_000_000 / FREQ_L) / 1000;

    localparam logic [31:0] TRIG_CYC     = TRIG_CYC_L[31:0];
    localparam logic [31:0] WAIT_CYC     = WAIT_CYC_L[31:0];
    localparam logic [31:0] MAX_CYC      = MAX_CYC_L[31:0];
    localparam logic [31:0] HOLD_CYC     = HOLD_CYC_L[31:0];
    localparam logic [31:0] NM_PER_CYCLE = NM_L[31:0];
    localparam logic [31:0] NM_PER_MM    = 32'd2_000_000;  // round trip: 2 mm of path per mm of range

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] cnt;
    logic [31:0] cnt_nx;
    logic [31:0] acc;
    logic [31:0] acc_sum;
    logic [15:0] mm;
    logic        echo_m;
    logic        echo_s;
    logic        echo_d;
    logic        echo_rise;
    logic        acc_add;
    logic        clr;
    logic        res_fire;
    logic        res_to;

    assign echo_rise = echo_s & ~echo_d;
    assign busy      = (state != IDLE);
    assign acc_sum   = acc + (acc_add ? NM_PER_CYCLE : 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // cnt is the per-state phase counter; in MEASURE it holds the number of high cycles already accumulated
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 32'd1;
        acc_add  = 1'b0;
        clr      = 1'b0;
        res_fire = 1'b0;
        res_to   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx = TRIG;
                    clr      = 1'b1;
                end
            end
            TRIG: begin
                if (cnt == TRIG_CYC - 32'd1) begin
                    state_nx = WAIT_ECHO;
                    cnt_nx   = '0;
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_nx = MEASURE;
                    cnt_nx   = 32'd1;
                    acc_add  = 1'b1;
                end else if (cnt == WAIT_CYC - 32'd1) begin
                    state_nx = HOLDOFF;
                    cnt_nx   = '0;
                    res_fire = 1'b1;
                    res_to   = 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_nx = HOLDOFF;
                    cnt_nx   = '0;
                    res_fire = 1'b1;
                end else if (cnt >= MAX_CYC) begin
                    state_nx = HOLDOFF;
                    cnt_nx   = '0;
                    res_fire = 1'b1;
                    res_to   = 1'b1;
                end else begin
                    acc_add = 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt == HOLD_CYC - 32'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            mm          <= '0;
            echo_m      <= 1'b0;
            echo_s      <= 1'b0;
            echo_d      <= 1'b0;
            trig        <= 1'b0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            distance_mm <= '0;
        end else begin
            cnt    <= cnt_nx;
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
            trig   <= (state_nx == TRIG);
            valid  <= res_fire;
            if (res_fire) begin
                timeout     <= res_to;
                distance_mm <= res_to ? 16'hFFFF : mm;
            end
            // acc stays below NM_PER_MM and NM_PER_CYCLE is smaller, so one subtraction per cycle suffices
            if (clr) begin
                acc <= '0;
                mm  <= '0;
            end else if (acc_sum >= NM_PER_MM) begin
                acc <= acc_sum - NM_PER_MM;
                if (mm != 16'hFFFE) begin
                    mm <= mm + 16'd1;
                end
            end else begin
                acc <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger at 1 MHz (one cycle per us): expected results queued, monitor compares on valid.
module tb_sonar_ranger;

    logic        clk;
    logic        rst;
    logic        start;
    logic        echo;
    logic        trig;
    logic        busy;
    logic        valid;
    logic        timeout;
    logic [15:0] distance_mm;

    typedef struct {
        logic        to;
        logic [15:0] mm;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   vcount  = 0;
    int   tpulses = 0;
    int   twidth  = 0;
    int   nstarts = 0;

    sonar_ranger #(
        .FREQ        (1_000_000),
        .TRIG_US     (10),
        .ECHO_WAIT_US(200),
        .MAX_ECHO_US (300),
        .HOLDOFF_US  (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .echo       (echo),
        .trig       (trig),
        .busy       (busy),
        .valid      (valid),
        .timeout    (timeout),
        .distance_mm(distance_mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: result scoreboard and trigger pulse width
    always @(negedge clk) begin
        if (rst) begin
            twidth = 0;
        end else begin
            if (valid) begin
                vcount++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("timeout", {31'd0, timeout}, {31'd0, e.to});
                    check("distance_mm", {16'd0, distance_mm}, {16'd0, e.mm});
                end
            end
            if (trig) begin
                twidth++;
            end else if (twidth != 0) begin
                check("trig_width", twidth, 32'd10);
                tpulses++;
                twidth = 0;
            end
        end
    end

    task automatic expect_result(input logic to, input logic [15:0] mm);
        exp_t e;
        e.to = to;
        e.mm = mm;
        exp_q.push_back(e);
        nstarts++;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_trig_fall();
        bit seen = 0;
        bit ok   = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (trig) seen = 1;
            else if (seen) begin
                ok = 1;
                break;
            end
        end
        check("trig_fall_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("return_to_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic echo_high(input int n);
        #1 echo = 1'b1;
        repeat (n) @(posedge clk);
        #1 echo = 1'b0;
    endtask

    task automatic measure(input int gap, input int n, input logic to, input logic [15:0] mm);
        expect_result(to, mm);
        pulse_start();
        wait_trig_fall();
        repeat (gap) @(posedge clk);
        echo_high(n);
        wait_idle();
        check("hold_distance", {16'd0, distance_mm}, {16'd0, mm});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        echo  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_trig", {31'd0, trig}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_dist", {16'd0, distance_mm}, 32'd0);

        // floor(N*343210/2e6): 100->17, 6->1, 5->0, 35->6, 34->5, 300->51, 301 high cycles -> timeout
        measure(3, 100, 1'b0, 16'd17);
        measure(1, 6, 1'b0, 16'd1);
        measure(4, 5, 1'b0, 16'd0);
        measure(2, 35, 1'b0, 16'd6);
        measure(2, 34, 1'b0, 16'd5);
        measure(5, 300, 1'b0, 16'd51);
        measure(5, 301, 1'b1, 16'hFFFF);

        // No echo: timeout exactly 200 cycles after trig falls
        begin
            int c = 0;
            expect_result(1'b1, 16'hFFFF);
            pulse_start();
            wait_trig_fall();
            check("busy_waiting", {31'd0, busy}, 32'd1);
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                c++;
                if (valid) break;
            end
            check("noecho_latency", c, 32'd200);
            wait_idle();
        end

        // Echo stuck high from before start: never enters MEASURE
        #1 echo = 1'b1;
        repeat (5) @(posedge clk);
        expect_result(1'b1, 16'hFFFF);
        pulse_start();
        wait_trig_fall();
        wait_idle();
        #1 echo = 1'b0;
        repeat (5) @(posedge clk);

        // Echo rising during TRIG must be ignored until it falls and rises again
        expect_result(1'b0, 16'd6);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 echo = 1'b1;
        wait_trig_fall();
        repeat (5) @(posedge clk);
        #1 echo = 1'b0;
        repeat (4) @(posedge clk);
        echo_high(35);
        wait_idle();

        // Extra starts during TRIG, MEASURE and HOLDOFF are ignored
        expect_result(1'b0, 16'd17);
        pulse_start();
        pulse_start();
        wait_trig_fall();
        repeat (2) @(posedge clk);
        #1 echo = 1'b1;
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (59) @(posedge clk);
        #1 echo = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid) break;
        end
        repeat (3) @(posedge clk);
        pulse_start();
        wait_idle();
        repeat (10) @(posedge clk);
        check("busy_after_ignored", {31'd0, busy}, 32'd0);

        // Reset in the middle of MEASURE: no result for the aborted measurement
        pulse_start();
        wait_trig_fall();
        repeat (2) @(posedge clk);
        #1 echo = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        echo = 1'b0;
        @(negedge clk);
        check("abort_trig", {31'd0, trig}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_timeout", {31'd0, timeout}, 32'd0);
        check("abort_dist", {16'd0, distance_mm}, 32'd0);
        repeat (30) @(posedge clk);
        nstarts++;
        measure(3, 100, 1'b0, 16'd17);

        repeat (10) @(posedge clk);
        check("trig_pulses", tpulses, nstarts);
        check("valid_count", vcount, nstarts - 1);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sonar_ranger.md
SONAR_RANGER -- requirements
Module: sonar_ranger

Interface
REQ-001 SHALL have parameter FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter TRIG_US, default 10, trig pulse width in us.
REQ-003 SHALL have parameter ECHO_WAIT_US, default 30000, maximum wait from trig fall to echo rise, in us.
REQ-004 SHALL have parameter MAX_ECHO_US, default 30000, maximum echo high time, in us.
REQ-005 SHALL have parameter HOLDOFF_US, default 100, dead time after each result, in us.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on posedge clk.
REQ-007 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit, measurement request, sampled in IDLE only.
REQ-009 SHALL have port echo, input, 1 bit, asynchronous echo from the sensor.
REQ-010 SHALL have port trig, output, 1 bit, registered trigger pulse to the sensor.
REQ-011 SHALL have port busy, output, 1 bit, high whenever state != IDLE.
REQ-012 SHALL have port valid, output, 1 bit, one-cycle result strobe.
REQ-013 SHALL have port timeout, output, 1 bit, result flag for no echo or echo too long.
REQ-014 SHALL have port distance_mm, output, 16 bits, measured one-way distance in mm.

Function
REQ-015 SHALL derive constants: TRIG_CYC=TRIG_US*FREQ/1e6, WAIT_CYC, MAX_CYC, HOLD_CYC likewise, and NM_PER_CYCLE=343210*(1e9/FREQ)/1000 (6864 at 50 MHz), all integer-truncated.
REQ-016 SHALL pass echo through a 2-flop synchronizer (echo_s) before any use; 2-cycle latency, identical on both edges.
REQ-017 SHALL implement states IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-018 IDLE: start=1 -> TRIG; start while busy SHALL be ignored, not queued.
REQ-019 TRIG: trig=1 for exactly TRIG_CYC cycles, rising in the cycle after start is sampled; then trig=0, -> WAIT_ECHO.
REQ-020 WAIT_ECHO: -> MEASURE only on an echo_s 0->1 transition; echo_s already high on entry SHALL not count until it falls and rises again.
REQ-021 WAIT_ECHO: no rise within WAIT_CYC cycles -> result with timeout=1.
REQ-022 MEASURE: every cycle with echo_s=1, starting at the rise-detect cycle, SHALL add NM_PER_CYCLE to a 32-bit accumulator; whenever acc>=2_000_000, subtract 2_000_000 and increment the mm count; mm = floor(N*NM_PER_CYCLE/2e6) for N high cycles.
REQ-023 mm count SHALL saturate at 16'hFFFE; no wrap.
REQ-024 MEASURE: first echo_s=0 cycle ends the measurement; result (timeout=0, distance_mm=mm) SHALL be presented with valid=1 in the following cycle.
REQ-025 MEASURE: echo_s still high after MAX_CYC cycles -> result with timeout=1, no wait for the echo fall.
REQ-026 Timeout result SHALL set distance_mm=16'hFFFF.
REQ-027 valid SHALL be high for exactly one cycle per accepted start; distance_mm and timeout SHALL hold until the next valid.
REQ-028 After valid, state SHALL be HOLDOFF for HOLD_CYC cycles, then IDLE; start during HOLDOFF SHALL be ignored.
REQ-029 Accumulator, mm count and phase counter SHALL clear on every entry to TRIG.

Reset
REQ-030 rst=1 at a clk edge SHALL force state=IDLE, trig=0, busy=0, valid=0, timeout=0, distance_mm=0, synchronizer=0, all counters=0, taking priority over start and echo.
REQ-031 rst asserted mid-measurement SHALL drop trig the next edge and produce no valid for the aborted measurement.

Verification
REQ-032 Nominal: FREQ=50e6, start pulse, echo high 291376 cycles -> trig high 500 cycles, one valid, distance_mm=1000, timeout=0.
REQ-033 Rounding: echo high 291375 cycles -> distance_mm=999.
REQ-034 No echo: start, echo held 0 -> valid exactly 1_500_000 cycles after trig fall (+sync latency), timeout=1, distance_mm=16'hFFFF.
REQ-035 Stuck echo: echo held 1 from before start -> no MEASURE entry, timeout result as above; echo high >1_500_000 cycles after a rise -> timeout=1.
REQ-036 Busy ignore: extra start pulses during TRIG, MEASURE and HOLDOFF -> exactly one trig pulse and one valid per accepted start.
REQ-037 Reset mid-MEASURE: rst=1 for 1 cycle -> trig=0, busy=0, outputs 0 next cycle, no valid; a new start then measures normally.
